// File: rtl/idelay_cal_pkg.sv
// idelay_cal_pkg: shared types and helpers for the IDELAY eye calibration engine
package idelay_cal_pkg;
    localparam int TAP_W = 9;
    localparam int RUN_W = 10;

    typedef enum logic [3:0] {
        S_IDLE, S_VTC_OFF, S_LOAD, S_SETTLE, S_SAMPLE, S_NEXT, S_FINAL_LOAD, S_VERIFY, S_VTC_ON
    } state_e;

    typedef struct packed {
        logic [TAP_W-1:0] start;
        logic [RUN_W-1:0] len;
    } window_t;

    function automatic logic [TAP_W-1:0] mid_tap(input logic [TAP_W-1:0] l, input logic [TAP_W-1:0] r);
        return l + ((r - l) >> 1);
    endfunction
endpackage

// File: rtl/idelay_cal_window_tracker.sv
// idelay_cal_window_tracker: tracks the current passing run and the widest run seen so far
module idelay_cal_window_tracker
    import idelay_cal_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic             pass_i,
    input  logic             last_i,
    output logic [TAP_W-1:0] best_start_o,
    output logic [RUN_W-1:0] best_len_o
);
    window_t run_q, run_d, best_q, best_d, ext, cand;
    logic [TAP_W-1:0] idx_q, idx_d;
    logic close;

    always_comb begin
        ext.start = (run_q.len == '0) ? idx_q : run_q.start;
        ext.len   = run_q.len + RUN_W'(1);
        cand      = pass_i ? ext : run_q;
        close     = !pass_i || last_i;
        run_d     = run_q;
        best_d    = best_q;
        idx_d     = idx_q;
        if (clear_i) begin
            run_d  = '0;
            best_d = '0;
            idx_d  = '0;
        end else if (step_i) begin
            idx_d = idx_q + TAP_W'(1);
            run_d = close ? '0 : ext;
            // strictly longer only, so the lowest-tap window wins ties
            if (close && cand.len > best_q.len) best_d = cand;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q  <= '0;
            best_q <= '0;
            idx_q  <= '0;
        end else begin
            run_q  <= run_d;
            best_q <= best_d;
            idx_q  <= idx_d;
        end
    end

    assign best_start_o = best_q.start;
    assign best_len_o   = best_q.len;
endmodule

// File: rtl/idelay_eye_cal.sv
// idelay_eye_cal: sweeps IDELAYE3 taps via VAR_LOAD, finds the widest passing eye and loads its centre
module idelay_eye_cal
    import idelay_cal_pkg::*;
#(
    parameter int unsigned TAP_MAX       = 511,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLE_COUNT  = 16,
    parameter int unsigned MIN_EYE       = 16,
    parameter int unsigned DEFAULT_TAP   = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [7:0]       train_pattern_i,
    input  logic [7:0]       sample_data_i,
    input  logic             sample_valid_i,
    input  logic [TAP_W-1:0] dly_cntvalueout_i,
    output logic             dly_ce_o,
    output logic             dly_load_o,
    output logic             dly_inc_o,
    output logic [TAP_W-1:0] dly_cntvaluein_o,
    output logic             dly_en_vtc_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [TAP_W-1:0] eye_left_o,
    output logic [TAP_W-1:0] eye_right_o,
    output logic [TAP_W-1:0] eye_center_o
);
    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      SAMPLE_LAST = 16'(SAMPLE_COUNT - 1);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(TAP_MAX);

    state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [TAP_W-1:0] tap_q, tap_d, cntin_q, cntin_d;
    logic [TAP_W-1:0] left_q, left_d, right_q, right_d, center_q, center_d;
    logic pass_q, pass_d, ok_q, ok_d, ce_q, ce_d, vtc_q, vtc_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic accept, good;
    logic [TAP_W-1:0] best_start, fin_left, fin_right, fin_center;
    logic [RUN_W-1:0] best_len;

    idelay_cal_window_tracker u_tracker (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .clear_i      (accept),
        .step_i       (state_q == S_NEXT),
        .pass_i       (pass_q),
        .last_i       (tap_q == TAP_LAST),
        .best_start_o (best_start),
        .best_len_o   (best_len)
    );

    // START is also taken in VTC_ON, the cycle that transitions back into IDLE
    assign accept     = start_i && (state_q == S_IDLE || state_q == S_VTC_ON);
    assign good       = best_len >= RUN_W'(MIN_EYE);
    assign fin_left   = good ? best_start : '0;
    assign fin_right  = good ? best_start + TAP_W'(best_len - RUN_W'(1)) : '0;
    assign fin_center = good ? mid_tap(fin_left, fin_right) : TAP_W'(DEFAULT_TAP);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        tap_d    = tap_q;
        pass_d   = pass_q;
        ok_d     = ok_q;
        left_d   = left_q;
        right_d  = right_q;
        center_d = center_q;
        case (state_q)
            S_VTC_OFF: state_d = (cnt_q == SETTLE_LAST) ? S_LOAD : S_VTC_OFF;
            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE: begin
                state_d = (cnt_q == SETTLE_LAST) ? S_SAMPLE : S_SETTLE;
                cnt_d   = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 16'd1;
            end
            S_SAMPLE: begin
                cnt_d = cnt_q;
                if (sample_valid_i) begin
                    if (sample_data_i != train_pattern_i) begin
                        pass_d  = 1'b0;
                        state_d = S_NEXT;
                    end else if (cnt_q == SAMPLE_LAST) begin
                        pass_d  = 1'b1;
                        state_d = S_NEXT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_NEXT: begin
                state_d = (tap_q == TAP_LAST) ? S_FINAL_LOAD : S_LOAD;
                tap_d   = (tap_q == TAP_LAST) ? tap_q : tap_q + TAP_W'(1);
            end
            S_FINAL_LOAD: begin
                state_d  = S_VERIFY;
                cnt_d    = '0;
                ok_d     = good;
                left_d   = fin_left;
                right_d  = fin_right;
                center_d = fin_center;
            end
            S_VERIFY: begin
                // the centre load lands on the first VERIFY edge; readback is stable on the second cycle
                if (cnt_q == 16'd1) begin
                    state_d = S_VTC_ON;
                    ok_d    = ok_q && (dly_cntvalueout_i == center_q);
                end
            end
            S_VTC_ON: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_VTC_OFF;
            cnt_d   = '0;
            tap_d   = '0;
        end
    end

    assign ce_d    = (state_d == S_LOAD) || (state_q == S_FINAL_LOAD);
    assign cntin_d = (state_d == S_LOAD) ? tap_d : (state_q == S_FINAL_LOAD) ? fin_center : cntin_q;
    assign vtc_d   = (state_d == S_IDLE) || (state_d == S_VTC_ON);
    assign busy_d  = !vtc_d;
    assign done_d  = accept ? 1'b0 : (state_d == S_VTC_ON) ? ok_d : done_q;
    assign fail_d  = accept ? 1'b0 : (state_d == S_VTC_ON) ? !ok_d : fail_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tap_q    <= '0;
            pass_q   <= 1'b0;
            ok_q     <= 1'b0;
            ce_q     <= 1'b0;
            cntin_q  <= '0;
            vtc_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
            center_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tap_q    <= tap_d;
            pass_q   <= pass_d;
            ok_q     <= ok_d;
            ce_q     <= ce_d;
            cntin_q  <= cntin_d;
            vtc_q    <= vtc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            left_q   <= left_d;
            right_q  <= right_d;
            center_q <= center_d;
        end
    end

    assign dly_ce_o         = ce_q;
    assign dly_load_o       = ce_q;
    assign dly_inc_o        = 1'b0;
    assign dly_cntvaluein_o = cntin_q;
    assign dly_en_vtc_o     = vtc_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign fail_o           = fail_q;
    assign eye_left_o       = left_q;
    assign eye_right_o      = right_q;
    assign eye_center_o     = center_q;
endmodule
